// File: rtl/stage3_fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and the memory (slave).
interface stage3_fetch_stage_if;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_busy;
  logic [31:0] imem_rdata;
  logic        imem_fault;

  modport master (
    output imem_ren, imem_addr,
    input  imem_busy, imem_rdata, imem_fault
  );

  modport slave (
    input  imem_ren, imem_addr,
    output imem_busy, imem_rdata, imem_fault
  );
endinterface

// File: rtl/stage3_fetch_stage.sv
// Fetch stage: owns the PC, issues instruction reads, and fills the fetch/execute
// register while honouring stall, flush, redirect and trap requests.
module stage3_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] HART_ID  = 32'h0000_0000
) (
  input  logic                        CLK,
  input  logic                        nRST,
  stage3_fetch_stage_if.master        imem,
  input  logic                        stall_f,
  input  logic                        flush_f,
  input  logic                        redirect,
  input  logic [31:0]                 redirect_addr,
  input  logic                        trap_en,
  input  logic [31:0]                 trap_addr,
  input  logic                        pred_taken,
  input  logic [31:0]                 pred_target,
  output logic                        fetch_busy,
  output logic                        fe_valid,
  output logic                        fe_prediction,
  output logic                        fe_mal_insn,
  output logic                        fe_fault_insn,
  output logic [31:0]                 fe_pc,
  output logic [31:0]                 fe_pc4,
  output logic [31:0]                 fe_instr,
  output logic [31:0]                 fe_badaddr,
  output logic [31:0]                 fe_hart_id
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        prediction;
    logic        mal_insn;
    logic        fault_insn;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] badaddr;
  } pkt_t;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stale_addr_q, stale_addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_target_q, hold_target_d;
  logic        hold_fault_q, hold_fault_d;
  logic        hold_pred_q, hold_pred_d;
  pkt_t        pkt_q, pkt_d, pkt_new_s;

  logic        redir_s;
  logic [31:0] redir_target_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;
  logic        mal_s;
  logic        ready_s;
  logic        ren_s;
  logic [31:0] addr_s;

  // Next-PC selection: trap beats redirect beats prediction beats fall-through.
  always_comb begin
    redir_s        = trap_en | redirect;
    redir_target_s = trap_en ? trap_addr : redirect_addr;
    pc_plus4_s     = pc_q + 32'd4;
    mal_s          = (pc_q[1:0] != 2'b00);
    if (redir_s) begin
      next_pc_s = redir_target_s;
    end else if (pred_taken) begin
      next_pc_s = pred_target;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Fetch FSM: bus request, packet assembly and PC/hold/stale updates.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    stale_addr_d  = stale_addr_q;
    hold_instr_d  = hold_instr_q;
    hold_target_d = hold_target_q;
    hold_fault_d  = hold_fault_q;
    hold_pred_d   = hold_pred_q;
    ren_s         = 1'b0;
    addr_s        = pc_q;
    ready_s       = 1'b0;
    pkt_new_s     = '0;

    case (state_q)
      FETCH: begin
        if (mal_s) begin
          // No bus access; the misaligned packet repeats until the PC is redirected.
          ready_s              = !redir_s;
          pkt_new_s.valid      = 1'b1;
          pkt_new_s.mal_insn   = 1'b1;
          pkt_new_s.pc         = pc_q;
          pkt_new_s.pc4        = pc_plus4_s;
          pkt_new_s.badaddr    = pc_q;
          pc_d                 = redir_s ? redir_target_s : pc_q;
        end else begin
          ren_s = 1'b1;
          if (!imem.imem_busy) begin
            if (redir_s) begin
              pc_d = redir_target_s;
            end else if (stall_f) begin
              hold_instr_d  = imem.imem_rdata;
              hold_fault_d  = imem.imem_fault;
              hold_pred_d   = pred_taken;
              hold_target_d = pred_target;
              state_d       = HOLD;
            end else begin
              ready_s              = 1'b1;
              pkt_new_s.valid      = 1'b1;
              pkt_new_s.prediction = pred_taken;
              pkt_new_s.fault_insn = imem.imem_fault;
              pkt_new_s.pc         = pc_q;
              pkt_new_s.pc4        = pc_plus4_s;
              pkt_new_s.instr      = imem.imem_rdata;
              pkt_new_s.badaddr    = imem.imem_fault ? pc_q : 32'd0;
              pc_d                 = next_pc_s;
            end
          end else if (redir_s) begin
            // Request still in flight: keep the bus stable by finishing it in DISCARD.
            pc_d         = redir_target_s;
            stale_addr_d = pc_q;
            state_d      = DISCARD;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HOLD: begin
        if (redir_s) begin
          pc_d    = redir_target_s;
          state_d = FETCH;
        end else if (!stall_f) begin
          ready_s              = 1'b1;
          pkt_new_s.valid      = 1'b1;
          pkt_new_s.prediction = hold_pred_q;
          pkt_new_s.fault_insn = hold_fault_q;
          pkt_new_s.pc         = pc_q;
          pkt_new_s.pc4        = pc_plus4_s;
          pkt_new_s.instr      = hold_instr_q;
          pkt_new_s.badaddr    = hold_fault_q ? pc_q : 32'd0;
          pc_d                 = hold_pred_q ? hold_target_q : pc_plus4_s;
          state_d              = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DISCARD: begin
        ren_s   = 1'b1;
        addr_s  = stale_addr_q;
        pc_d    = redir_s ? redir_target_s : pc_q;
        state_d = imem.imem_busy ? DISCARD : FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Fetch/execute register: stall retains, flush clears, otherwise load packet or bubble.
  always_comb begin
    pkt_d = pkt_q;
    if (stall_f) begin
      pkt_d = pkt_q;
    end else if (flush_f) begin
      pkt_d = '0;
    end else if (ready_s) begin
      pkt_d = pkt_new_s;
    end else begin
      pkt_d.valid = 1'b0;
    end
  end

  // State, PC, hold buffer and packet registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      stale_addr_q  <= 32'd0;
      hold_instr_q  <= 32'd0;
      hold_target_q <= 32'd0;
      hold_fault_q  <= 1'b0;
      hold_pred_q   <= 1'b0;
      pkt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      stale_addr_q  <= stale_addr_d;
      hold_instr_q  <= hold_instr_d;
      hold_target_q <= hold_target_d;
      hold_fault_q  <= hold_fault_d;
      hold_pred_q   <= hold_pred_d;
      pkt_q         <= pkt_d;
    end
  end

  assign imem.imem_ren  = ren_s & nRST;
  assign imem.imem_addr = addr_s;
  assign fetch_busy     = !ready_s;
  assign fe_valid       = pkt_q.valid;
  assign fe_prediction  = pkt_q.prediction;
  assign fe_mal_insn    = pkt_q.mal_insn;
  assign fe_fault_insn  = pkt_q.fault_insn;
  assign fe_pc          = pkt_q.pc;
  assign fe_pc4         = pkt_q.pc4;
  assign fe_instr       = pkt_q.instr;
  assign fe_badaddr     = pkt_q.badaddr;
  assign fe_hart_id     = HART_ID;

endmodule

// File: tb/tb_stage3_fetch_stage.sv
// Bench for stage3_fetch_stage: directed scenarios plus a randomized run checked
// against a packet-stream model with a behavioural instruction memory.
module tb_stage3_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        stall_f, flush_f, redirect, trap_en, pred_taken;
  logic [31:0] redirect_addr, trap_addr, pred_target;
  logic        fetch_busy, fe_valid, fe_prediction, fe_mal_insn, fe_fault_insn;
  logic [31:0] fe_pc, fe_pc4, fe_instr, fe_badaddr, fe_hart_id;

  int          checks = 0;
  int          failures = 0;
  int          bus_wait_cfg = 0;
  bit          req_active = 1'b0;
  int          wait_left = 0;
  logic [31:0] req_addr = 32'd0;
  logic        pre_fetch_busy, pre_ren, pre_busy, pre_nrst;

  stage3_fetch_stage_if bus();

  stage3_fetch_stage #(.RESET_PC(RST_PC), .HART_ID(32'd0)) dut (
    .CLK(CLK), .nRST(nRST), .imem(bus),
    .stall_f(stall_f), .flush_f(flush_f),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .trap_en(trap_en), .trap_addr(trap_addr),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .fetch_busy(fetch_busy), .fe_valid(fe_valid), .fe_prediction(fe_prediction),
    .fe_mal_insn(fe_mal_insn), .fe_fault_insn(fe_fault_insn),
    .fe_pc(fe_pc), .fe_pc4(fe_pc4), .fe_instr(fe_instr),
    .fe_badaddr(fe_badaddr), .fe_hart_id(fe_hart_id)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic fault_at(input logic [31:0] a);
    return (a[7:4] == 4'h2);
  endfunction

  function automatic logic [131:0] snap();
    return {fe_valid, fe_prediction, fe_mal_insn, fe_fault_insn, fe_pc, fe_pc4, fe_instr, fe_badaddr};
  endfunction

  // Memory slave: each new request gets a wait count, then completes with mem_word().
  task automatic bus_drive();
    if (bus.imem_ren) begin
      if (!req_active) begin
        req_active = 1'b1;
        req_addr   = bus.imem_addr;
        wait_left  = (bus_wait_cfg < 0) ? int'($urandom_range(0, 3)) : bus_wait_cfg;
      end
      bus.imem_busy  = (wait_left > 0);
      bus.imem_rdata = mem_word(req_addr);
      bus.imem_fault = fault_at(req_addr);
    end else begin
      bus.imem_busy  = 1'b0;
      bus.imem_rdata = $urandom;
      bus.imem_fault = 1'b0;
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    bus_drive();
    #1;
    pre_fetch_busy = fetch_busy;
    pre_ren        = bus.imem_ren;
    pre_busy       = bus.imem_busy;
    pre_nrst       = nRST;
    @(posedge CLK);
    if (!pre_nrst) req_active = 1'b0;
    else if (pre_ren && !pre_busy) req_active = 1'b0;
    else if (pre_ren && pre_busy) wait_left--;
    #1;
  endtask

  task automatic clear_inputs();
    stall_f = 1'b0; flush_f = 1'b0; redirect = 1'b0; trap_en = 1'b0; pred_taken = 1'b0;
    redirect_addr = 32'd0; trap_addr = 32'd0; pred_target = RST_PC + 32'h40;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    cyc();
    cyc();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    bus_wait_cfg = 0;
    clear_inputs();
    nRST = 1'b0;
    cyc();
    cyc();
    checks++;
    if (snap() !== 132'd0) begin failures++; $display("FAIL reset_fe_zero: got %h expected 0", snap()); end
    checks++;
    if (fe_hart_id !== 32'd0) begin failures++; $display("FAIL reset_hart_id: got %h expected 0", fe_hart_id); end
    checks++;
    if (bus.imem_ren !== 1'b0) begin failures++; $display("FAIL reset_ren_low: got %b expected 0", bus.imem_ren); end
    nRST = 1'b1;
    #1;
    checks++;
    if ({bus.imem_ren, bus.imem_addr} !== {1'b1, RST_PC}) begin
      failures++; $display("FAIL reset_first_req: got ren=%b addr=%h expected ren=1 addr=%h", bus.imem_ren, bus.imem_addr, RST_PC);
    end
  endtask

  task automatic test_zero_wait();
    bus_wait_cfg = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] epc;
      epc = RST_PC + 32'(4 * i);
      cyc();
      checks++;
      if ({fe_valid, fe_pc, fe_pc4, fe_instr, fe_fault_insn} !== {1'b1, epc, epc + 32'd4, mem_word(epc), 1'b0}) begin
        failures++; $display("FAIL zero_wait[%0d]: got v=%b pc=%h pc4=%h instr=%h expected v=1 pc=%h pc4=%h instr=%h",
                             i, fe_valid, fe_pc, fe_pc4, fe_instr, epc, epc + 32'd4, mem_word(epc));
      end
    end
  endtask

  task automatic test_wait_states();
    bus_wait_cfg = 3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (fe_valid !== 1'b0) begin failures++; $display("FAIL wait_bubble[%0d]: got valid=%b expected 0", i, fe_valid); end
    end
    cyc();
    checks++;
    if ({fe_valid, fe_pc, fe_instr} !== {1'b1, RST_PC, mem_word(RST_PC)}) begin
      failures++; $display("FAIL wait_packet: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", fe_valid, fe_pc, fe_instr, RST_PC, mem_word(RST_PC));
    end
    bus_wait_cfg = 0;
  endtask

  task automatic test_stall_hold();
    bus_wait_cfg = 0;
    do_reset();
    cyc();
    stall_f = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if ({bus.imem_ren, fe_valid, fe_pc} !== {1'b0, 1'b1, RST_PC}) begin
        failures++; $display("FAIL stall_hold[%0d]: got ren=%b v=%b pc=%h expected ren=0 v=1 pc=%h", i, bus.imem_ren, fe_valid, fe_pc, RST_PC);
      end
    end
    stall_f = 1'b0;
    cyc();
    checks++;
    if ({fe_valid, fe_pc, fe_instr, bus.imem_ren, bus.imem_addr} !== {1'b1, RST_PC + 32'd4, mem_word(RST_PC + 32'd4), 1'b1, RST_PC + 32'd8}) begin
      failures++; $display("FAIL stall_release: got v=%b pc=%h instr=%h ren=%b addr=%h expected pc=%h next addr=%h",
                           fe_valid, fe_pc, fe_instr, bus.imem_ren, bus.imem_addr, RST_PC + 32'd4, RST_PC + 32'd8);
    end
    cyc();
    checks++;
    if ({fe_valid, fe_pc} !== {1'b1, RST_PC + 32'd8}) begin
      failures++; $display("FAIL stall_after: got v=%b pc=%h expected v=1 pc=%h", fe_valid, fe_pc, RST_PC + 32'd8);
    end
  endtask

  task automatic test_redirect_busy();
    bit got;
    got = 1'b0;
    bus_wait_cfg = 0;
    do_reset();
    redirect = 1'b1; redirect_addr = 32'h8000_0010;
    cyc();
    redirect = 1'b0;
    checks++;
    if ({fe_valid, bus.imem_addr} !== {1'b0, 32'h8000_0010}) begin
      failures++; $display("FAIL redir_idle: got v=%b addr=%h expected v=0 addr=80000010", fe_valid, bus.imem_addr);
    end
    bus_wait_cfg = 3;
    cyc();
    redirect = 1'b1; redirect_addr = 32'h8000_0100;
    cyc();
    redirect = 1'b0;
    bus_wait_cfg = 0;
    checks++;
    if ({bus.imem_ren, bus.imem_addr} !== {1'b1, 32'h8000_0010}) begin
      failures++; $display("FAIL redir_stale_hold: got ren=%b addr=%h expected ren=1 addr=80000010", bus.imem_ren, bus.imem_addr);
    end
    for (int n = 0; n < 12 && !got; n++) begin
      cyc();
      checks++;
      if (req_active && bus.imem_addr !== req_addr) begin
        failures++; $display("FAIL redir_addr_stable: got %h expected %h", bus.imem_addr, req_addr);
      end
      if (fe_valid) begin
        got = 1'b1;
        checks++;
        if (fe_pc !== 32'h8000_0100) begin failures++; $display("FAIL redir_target_pkt: got pc=%h expected 80000100", fe_pc); end
      end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL redir_timeout: got no packet expected pc=80000100"); end
  endtask

  task automatic test_trap_priority();
    bus_wait_cfg = 0;
    do_reset();
    trap_en = 1'b1; trap_addr = 32'h8000_0200;
    redirect = 1'b1; redirect_addr = 32'h8000_0300;
    cyc();
    clear_inputs();
    checks++;
    if (bus.imem_addr !== 32'h8000_0200) begin failures++; $display("FAIL trap_prio_addr: got %h expected 80000200", bus.imem_addr); end
    cyc();
    checks++;
    if ({fe_valid, fe_pc} !== {1'b1, 32'h8000_0200}) begin
      failures++; $display("FAIL trap_prio_pkt: got v=%b pc=%h expected v=1 pc=80000200", fe_valid, fe_pc);
    end
  endtask

  task automatic test_misaligned();
    bus_wait_cfg = 0;
    do_reset();
    redirect = 1'b1; redirect_addr = 32'h8000_0102;
    cyc();
    redirect = 1'b0;
    checks++;
    if (bus.imem_ren !== 1'b0) begin failures++; $display("FAIL mal_no_req: got ren=%b expected 0", bus.imem_ren); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if ({fe_valid, fe_mal_insn, fe_badaddr, fe_instr, fe_pc, bus.imem_ren, fetch_busy} !==
          {1'b1, 1'b1, 32'h8000_0102, 32'd0, 32'h8000_0102, 1'b0, 1'b0}) begin
        failures++; $display("FAIL mal_pkt[%0d]: got v=%b mal=%b bad=%h instr=%h pc=%h ren=%b fb=%b expected v=1 mal=1 bad=80000102 instr=0 ren=0 fb=0",
                             i, fe_valid, fe_mal_insn, fe_badaddr, fe_instr, fe_pc, bus.imem_ren, fetch_busy);
      end
    end
    trap_en = 1'b1; trap_addr = RST_PC;
    cyc();
    clear_inputs();
    checks++;
    if ({bus.imem_ren, bus.imem_addr} !== {1'b1, RST_PC}) begin
      failures++; $display("FAIL mal_recover: got ren=%b addr=%h expected ren=1 addr=%h", bus.imem_ren, bus.imem_addr, RST_PC);
    end
  endtask

  task automatic test_fault();
    bus_wait_cfg = 0;
    do_reset();
    redirect = 1'b1; redirect_addr = 32'h8000_0020;
    cyc();
    redirect = 1'b0;
    cyc();
    checks++;
    if ({fe_valid, fe_fault_insn, fe_badaddr, fe_pc} !== {1'b1, 1'b1, 32'h8000_0020, 32'h8000_0020}) begin
      failures++; $display("FAIL fault_pkt: got v=%b fault=%b bad=%h pc=%h expected v=1 fault=1 bad=80000020", fe_valid, fe_fault_insn, fe_badaddr, fe_pc);
    end
  endtask

  task automatic test_flush();
    logic [131:0] held;
    bus_wait_cfg = 0;
    do_reset();
    cyc();
    flush_f = 1'b1;
    cyc();
    flush_f = 1'b0;
    checks++;
    if (snap() !== 132'd0) begin failures++; $display("FAIL flush_zero: got %h expected 0", snap()); end
    cyc();
    held = snap();
    stall_f = 1'b1; flush_f = 1'b1;
    cyc();
    clear_inputs();
    checks++;
    if (snap() !== held || fe_valid !== 1'b1) begin
      failures++; $display("FAIL stall_beats_flush: got %h expected %h", snap(), held);
    end
  endtask

  task automatic test_random();
    logic [31:0]  exp_pc;
    logic [131:0] prev;
    int           packets;
    packets = 0;
    bus_wait_cfg = -1;
    do_reset();
    exp_pc = RST_PC;
    pred_target = 32'h8000_0080;
    for (int n = 0; n < 800; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      nRST       = ($urandom_range(0, 199) != 0);
      stall_f    = ($urandom_range(0, 4) == 0);
      trap_en    = (r < 3);
      redirect   = (r >= 3 && r < 9);
      flush_f    = (trap_en || redirect) && ($urandom_range(0, 1) == 1);
      pred_taken = ($urandom_range(0, 9) == 0);
      trap_addr  = RST_PC | ($urandom_range(0, 63) << 2);
      redirect_addr = RST_PC | ($urandom_range(0, 63) << 2) | (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
      prev = snap();
      cyc();
      checks++;
      if (req_active && (bus.imem_addr !== req_addr || bus.imem_ren !== 1'b1)) begin
        failures++; $display("FAIL rnd_bus_stable[%0d]: got ren=%b addr=%h expected ren=1 addr=%h", n, bus.imem_ren, bus.imem_addr, req_addr);
      end
      if (!nRST) begin
        checks++;
        if (snap() !== 132'd0 || pre_ren !== 1'b0) begin failures++; $display("FAIL rnd_reset[%0d]: got %h ren=%b expected 0", n, snap(), pre_ren); end
        exp_pc = RST_PC;
      end else if (stall_f) begin
        checks++;
        if (snap() !== prev) begin failures++; $display("FAIL rnd_stall_retain[%0d]: got %h expected %h", n, snap(), prev); end
      end else if (flush_f) begin
        checks++;
        if (snap() !== 132'd0) begin failures++; $display("FAIL rnd_flush[%0d]: got %h expected 0", n, snap()); end
      end else begin
        checks++;
        if (fe_valid !== !pre_fetch_busy || (fe_valid && (trap_en || redirect))) begin
          failures++; $display("FAIL rnd_valid_busy[%0d]: got v=%b fetch_busy=%b redir=%b", n, fe_valid, pre_fetch_busy, trap_en | redirect);
        end
        if (fe_valid) begin
          logic [131:0] want;
          packets++;
          if (exp_pc[1:0] != 2'b00)
            want = {1'b1, 1'b0, 1'b1, 1'b0, exp_pc, exp_pc + 32'd4, 32'd0, exp_pc};
          else
            want = {1'b1, fe_prediction, 1'b0, fault_at(exp_pc), exp_pc, exp_pc + 32'd4, mem_word(exp_pc),
                    fault_at(exp_pc) ? exp_pc : 32'd0};
          checks++;
          if (snap() !== want) begin failures++; $display("FAIL rnd_packet[%0d]: got %h expected %h", n, snap(), want); end
          if (exp_pc[1:0] == 2'b00) exp_pc = fe_prediction ? pred_target : exp_pc + 32'd4;
        end
      end
      if (nRST && (trap_en || redirect)) exp_pc = trap_en ? trap_addr : redirect_addr;
    end
    clear_inputs();
    nRST = 1'b1;
    checks++;
    if (packets < 60) begin failures++; $display("FAIL rnd_progress: got %0d packets expected at least 60", packets); end
  endtask

  initial begin
    bus.imem_busy = 1'b0; bus.imem_rdata = 32'd0; bus.imem_fault = 1'b0;
    clear_inputs();
    nRST = 1'b0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_redirect_busy();
    test_trap_priority();
    test_misaligned();
    test_fault();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stage3_fetch_stage.md
# stage3_fetch_stage

Fetch stage of the three-stage pipeline. It owns the program counter and issues instruction reads on the instruction memory bus. It registers each returned instruction into the fetch/execute pipeline register that the execute stage consumes. It handles stall, flush and redirect requests from the hazard unit, and tags misaligned and faulting fetches so they are trapped at commit.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- HART_ID, 0, value driven on fe_hart_id

- CLK  in  1  clock
- nRST  in  1  reset; synchronous, active-low
- imem_ren  out  1  instruction read request
- imem_addr  out  32  read address; held stable while imem_busy
- imem_busy  in  1  high while a request is pending; low with imem_ren high means completion this cycle
- imem_rdata  in  32  instruction word, valid on completion
- imem_fault  in  1  access fault, valid on completion
- stall_f  in  1  hold the fetch/execute register (execute stalled)
- flush_f  in  1  squash the fetch/execute register
- redirect  in  1  PC redirect from branch/jump resolution
- redirect_addr  in  32  redirect target
- trap_en  in  1  PC redirect to trap/return vector; priority over redirect
- trap_addr  in  32  trap vector
- pred_taken  in  1  predictor says taken for current pc (combinational)
- pred_target  in  32  predicted target
- fetch_busy  out  1  to hazard unit: fetch has no packet ready this cycle
- fe_valid, fe_prediction, fe_mal_insn, fe_fault_insn  out  1 each  packet flags
- fe_pc, fe_pc4, fe_instr, fe_badaddr  out  32 each  packet words
- fe_hart_id  out  32  HART_ID

## Operation
- States: FETCH (issue/await request), HOLD (instruction captured, waiting for stall_f low), DISCARD (finish stale request after redirect).
- next_pc priority: trap_en ? trap_addr : redirect ? redirect_addr : pred_taken ? pred_target : pc+4 (mod 2^32).
- FETCH: imem_ren=1 and imem_addr=pc when pc[1:0]==0.
  - Completion, no trap_en/redirect, !stall_f: load the packet: valid=1, pc, pc4=pc+4, instr=imem_rdata, prediction=pred_taken, fault_insn=imem_fault, badaddr=imem_fault?pc:0. pc<=next_pc.
  - Completion with stall_f: capture rdata, fault and prediction into the hold buffer. Go to HOLD. pc unchanged.
  - trap_en/redirect while busy: pc<=target. Latch the old address into stale_addr. Go to DISCARD.
  - trap_en/redirect on the completion cycle: data dropped. pc<=target. Stay in FETCH.
- Misaligned pc (pc[1:0]!=0) in FETCH: imem_ren=0. Packet is valid=1, mal_insn=1, badaddr=pc, instr=0. pc<=next_pc only on trap_en/redirect; otherwise pc holds and the packet repeats until a trap redirect.
- HOLD: imem_ren=0.
  - stall_f low: load the packet from the hold buffer, pc<=next_pc (prediction as captured), go to FETCH.
  - trap_en/redirect: buffer dropped, pc<=target, go to FETCH.
- DISCARD: imem_ren=1, imem_addr=stale_addr. On completion, data dropped and state goes to FETCH. A further redirect updates pc only.
- Packet register, priority high to low:
  - stall_f: retain the packet (flush ignored).
  - flush_f: all fields 0.
  - Packet ready this cycle: load it.
  - Otherwise: load a bubble (fe_valid=0, other fields unchanged).
- fetch_busy = !(packet ready this cycle).

## Timing
- Reset (nRST sampled low at a CLK edge):
  - pc=RESET_PC, state=FETCH, hold buffer and stale_addr cleared.
  - All fe_* outputs 0 except fe_hart_id=HART_ID.
  - imem_ren=0 while nRST is low.
- Reset mid-request: the outstanding bus request is abandoned; no data is captured.
- Zero-wait bus: the packet appears on fe_* the cycle after imem_ren. Throughput is 1 instruction/cycle.
- N wait cycles: packet at cycle N+1, with fe_valid=0 bubbles before it.
- Redirect at cycle t with no request outstanding: imem_addr=target at t+1.
- imem_addr and imem_ren are never changed while imem_busy=1 (DISCARD guarantees this).
- Stall and flush in the same cycle: stall wins.

## Test plan
- Reset then zero-wait bus with sequential instructions: fe_pc=0x80000000, 0x80000004, 0x80000008 on consecutive cycles with fe_valid=1; fe_pc4=fe_pc+4.
- Bus busy 3 cycles on the first fetch: fe_valid=0 for 3 cycles, then fe_instr=rdata, fe_pc=0x80000000.
- stall_f high on the completion cycle for 2 cycles: state HOLD, imem_ren=0, fe_* unchanged. After release, the held instruction is loaded once and the next fetch goes to 0x80000004.
- redirect to 0x80000100 while busy on 0x80000010:
  - 0x80000010 is held on imem_addr until completion and its data dropped.
  - The next request goes to 0x80000100.
  - No packet carries pc 0x80000010.
- trap_en and redirect asserted together: pc=trap_addr.
- redirect to 0x80000102: no bus request. Packet has fe_mal_insn=1, fe_badaddr=0x80000102, fe_valid=1.
- imem_fault on completion at 0x80000020: fe_fault_insn=1, fe_badaddr=0x80000020.
- flush_f without stall: fe_valid=0 next cycle.
